// File: rtl/reproductor_pwm_if.sv
// Write-side bus of the PWM audio player.
//   master : sample producer, drives dato/wr_en and watches the FIFO status
//   slave  : reproductor_pwm, accepts samples and reports lleno/vacio/nivel
// Signals:
//   dato  [ANCHO_MUESTRA-1:0] unsigned sample, midscale = silence
//   wr_en                     one sample per cycle
//   lleno / vacio             FIFO full / empty
//   nivel [log2(PROF_FIFO):0] FIFO occupancy
interface reproductor_pwm_if #(
  parameter int ANCHO_MUESTRA = 8,
  parameter int PROF_FIFO     = 8
);
  localparam int AW = $clog2(PROF_FIFO);

  logic [ANCHO_MUESTRA-1:0] dato;
  logic                     wr_en;
  logic                     lleno;
  logic                     vacio;
  logic [AW:0]              nivel;

  modport master (output dato, output wr_en, input lleno, input vacio, input nivel);
  modport slave  (input dato, input wr_en, output lleno, output vacio, output nivel);
endinterface

// File: rtl/reproductor_pwm.sv
// PWM audio player: samples are buffered in a FIFO, one sample is consumed
// per rising edge of clk_muestra and played as the duty cycle of a
// free-running PWM counter. Duty changes only at PWM period boundaries.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   clk_muestra     sample-rate square wave; each rising edge requests a sample
//   clr_err         clears the sticky subdesborde/desborde flags
//   vol [1:0]       volume shift, present only with AUDIO_VOLUMEN_EN defined
//   bus (slave)     dato/wr_en in, lleno/vacio/nivel out
//   pwm_out         registered PWM output
//   reproduciendo   high while playing
//   subdesborde     sticky underrun flag, desborde sticky overflow flag
// Optional feature macro: AUDIO_VOLUMEN_EN (adds vol input and sample scaling).
module reproductor_pwm #(
  parameter int ANCHO_MUESTRA = 8,
  parameter int PROF_FIFO     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_muestra,
  input  logic clr_err,
`ifdef AUDIO_VOLUMEN_EN
  input  logic [1:0] vol,
`endif
  reproductor_pwm_if.slave bus,
  output logic pwm_out,
  output logic reproduciendo,
  output logic subdesborde,
  output logic desborde
);
  localparam int W  = ANCHO_MUESTRA;
  localparam int AW = $clog2(PROF_FIFO);
  localparam int NW = AW + 1;

  localparam logic [W-1:0]  MEDIO        = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  CNT_MAX      = {W{1'b1}};
  localparam logic [W-1:0]  CNT_UNO      = W'(1);
  localparam logic [AW-1:0] PTR_UNO      = AW'(1);
  localparam logic [NW-1:0] NIVEL_UNO    = NW'(1);
  localparam logic [NW-1:0] NIVEL_CERO   = NW'(0);
  localparam logic [NW-1:0] NIVEL_LLENO  = NW'(PROF_FIFO);
  localparam logic [NW-1:0] NIVEL_UMBRAL = NW'(PROF_FIFO / 2);

  typedef enum logic [0:0] {ESPERA = 1'b0, REPRODUCE = 1'b1} estado_t;

  estado_t       estado_q, estado_d;
  logic [W-1:0]  mem_q [PROF_FIFO];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] nivel_q, nivel_d;
  logic [W-1:0]  cnt_q;
  logic [W-1:0]  duty_pend_q, duty_pend_d;
  logic [W-1:0]  duty_act_q;
  logic          pwm_q, sub_q, des_q, clk_muestra_q;
  logic          tick_s, lleno_s, vacio_s, wr_ok_s, pop_s, sub_set_s;
  logic [W-1:0]  muestra_s;

`ifdef AUDIO_VOLUMEN_EN
  // Scale the excursion around midscale by 2^-v, keeping the sign.
  function automatic logic [W-1:0] escala_vol(input logic [W-1:0] m, input logic [1:0] v);
    logic signed [W:0] dif;
    dif = $signed({1'b0, m}) - $signed({1'b0, MEDIO});
    dif = dif >>> v;
    return MEDIO + dif[W-1:0];
  endfunction

  assign muestra_s = escala_vol(mem_q[rd_ptr_q], vol);
`else
  assign muestra_s = mem_q[rd_ptr_q];
`endif

  // Rising edge of clk_muestra; the registered copy resets low, so the
  // first cycle after reset is always spent in ESPERA where ticks are ignored.
  assign tick_s  = clk_muestra & ~clk_muestra_q;
  // Status comes from the registered level, so a write while full is
  // dropped even if a pop frees a slot in the same cycle.
  assign lleno_s = (nivel_q == NIVEL_LLENO);
  assign vacio_s = (nivel_q == NIVEL_CERO);
  assign wr_ok_s = bus.wr_en & ~lleno_s;

  // Player FSM: next state, pending duty, pop and underrun strobes.
  always_comb begin
    estado_d    = estado_q;
    duty_pend_d = duty_pend_q;
    pop_s       = 1'b0;
    sub_set_s   = 1'b0;
    case (estado_q)
      ESPERA: begin
        duty_pend_d = MEDIO;
        if (nivel_q >= NIVEL_UMBRAL) begin
          estado_d = REPRODUCE;
        end else begin
          estado_d = ESPERA;
        end
      end
      REPRODUCE: begin
        if (tick_s && !vacio_s) begin
          pop_s       = 1'b1;
          duty_pend_d = muestra_s;
        end else if (tick_s) begin
          sub_set_s   = 1'b1;
          duty_pend_d = MEDIO;
          estado_d    = ESPERA;
        end else begin
          duty_pend_d = duty_pend_q;
        end
      end
      default: begin
        estado_d    = ESPERA;
        duty_pend_d = MEDIO;
      end
    endcase
  end

  // FIFO occupancy: simultaneous write and pop leave the level unchanged.
  always_comb begin
    nivel_d = nivel_q;
    if (wr_ok_s && !pop_s) begin
      nivel_d = nivel_q + NIVEL_UNO;
    end else if (pop_s && !wr_ok_s) begin
      nivel_d = nivel_q - NIVEL_UNO;
    end else begin
      nivel_d = nivel_q;
    end
  end

  // Sample storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= bus.dato;
    end
  end

  // Control, PWM and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_muestra_q <= 1'b0;
      estado_q      <= ESPERA;
      nivel_q       <= NIVEL_CERO;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      duty_pend_q   <= MEDIO;
      duty_act_q    <= MEDIO;
      cnt_q         <= {W{1'b0}};
      pwm_q         <= 1'b0;
      sub_q         <= 1'b0;
      des_q         <= 1'b0;
    end else begin
      clk_muestra_q <= clk_muestra;
      estado_q      <= estado_d;
      nivel_q       <= nivel_d;
      if (wr_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_UNO;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_UNO;
      end
      duty_pend_q <= duty_pend_d;
      cnt_q       <= cnt_q + CNT_UNO;
      // Duty is only picked up as the counter wraps, never mid-period.
      if (cnt_q == CNT_MAX) begin
        duty_act_q <= duty_pend_q;
      end
      pwm_q <= (cnt_q < duty_act_q);
      // A new error in the clearing cycle wins over clr_err.
      sub_q <= (sub_q & ~clr_err) | sub_set_s;
      des_q <= (des_q & ~clr_err) | (bus.wr_en & lleno_s);
    end
  end

  assign bus.lleno     = lleno_s;
  assign bus.vacio     = vacio_s;
  assign bus.nivel     = nivel_q;
  assign pwm_out       = pwm_q;
  assign reproduciendo = (estado_q == REPRODUCE);
  assign subdesborde   = sub_q;
  assign desborde      = des_q;
endmodule

// File: tb/tb_reproductor_pwm.sv
module tb_reproductor_pwm;
  localparam int W    = 8;
  localparam int PROF = 8;

  logic clk = 1'b0;
  logic reset, clk_muestra, clr_err;
  logic pwm_out, reproduciendo, subdesborde, desborde;
`ifdef AUDIO_VOLUMEN_EN
  logic [1:0] vol;
`endif

  reproductor_pwm_if #(.ANCHO_MUESTRA(W), .PROF_FIFO(PROF)) bus_if ();

  reproductor_pwm #(.ANCHO_MUESTRA(W), .PROF_FIFO(PROF)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_muestra   (clk_muestra),
    .clr_err       (clr_err),
`ifdef AUDIO_VOLUMEN_EN
    .vol           (vol),
`endif
    .bus           (bus_if),
    .pwm_out       (pwm_out),
    .reproduciendo (reproduciendo),
    .subdesborde   (subdesborde),
    .desborde      (desborde)
  );

  always #5 clk = ~clk;

  // Status expectations: sel 0 nivel, 1 lleno, 2 vacio, 3 reproduciendo,
  // 4 subdesborde, 5 desborde, 6 pwm_out.
  typedef struct {
    int    sel;
    int    val;
    string nm;
  } chk_t;

  chk_t chk_q[$];
  int   duty_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  event chk_ev;
  bit   mon_en = 1'b0;
  int   cyc;

  function automatic logic [31:0] leer(input int sel);
    case (sel)
      0:       return 32'(bus_if.nivel);
      1:       return 32'(bus_if.lleno);
      2:       return 32'(bus_if.vacio);
      3:       return 32'(reproduciendo);
      4:       return 32'(subdesborde);
      5:       return 32'(desborde);
      6:       return 32'(pwm_out);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Status monitor: compares queued expectations at the inactive edge or on demand.
  initial begin : monitor_estado
    chk_t        c;
    logic [31:0] got;
    forever begin
      @(negedge clk or chk_ev);
      while (chk_q.size() > 0) begin
        c   = chk_q.pop_front();
        got = leer(c.sel);
        n_vec++;
        if (got !== 32'(c.val)) begin
          n_err++;
          $display("FAIL %s: got %0d, expected %0d", c.nm, got, c.val);
        end
      end
    end
  end

  // Clock edges since reset release; the PWM counter equals cyc mod 256.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Duty monitor: counts pwm_out highs over each aligned 256-cycle period
  // and checks every change of that count against the next expected duty.
  initial begin : monitor_duty
    int hi;
    bit full;
    int prev;
    int esp;
    hi = 0; full = 1'b0; prev = -1;
    forever begin
      @(negedge clk);
      if (!mon_en) prev = -1;
      if (!reset && cyc > 0) begin
        if ((cyc - 1) % 256 == 0) begin
          hi   = 0;
          full = mon_en;
        end
        if (pwm_out === 1'b1) hi++;
        if ((cyc % 256) == 0 && full && mon_en && hi != prev) begin
          n_vec++;
          if (duty_q.size() == 0) begin
            n_err++;
            $display("FAIL duty_change: got %0d high counts, expected no change from %0d", hi, prev);
          end else begin
            esp = duty_q.pop_front();
            if (hi != esp) begin
              n_err++;
              $display("FAIL duty_period: got %0d high counts, expected %0d", hi, esp);
            end
          end
          prev = hi;
        end
      end else begin
        full = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic escribir(input logic [W-1:0] d);
    bus_if.wr_en = 1'b1;
    bus_if.dato  = d;
    step();
    bus_if.wr_en = 1'b0;
  endtask

  task automatic chk(input int sel, input int val, input string nm);
    chk_t c;
    c.sel = sel;
    c.val = val;
    c.nm  = nm;
    chk_q.push_back(c);
  endtask

  task automatic pulso(input int alto, input int bajo);
    clk_muestra = 1'b1;
    repeat (alto) step();
    clk_muestra = 1'b0;
    repeat (bajo) step();
  endtask

  // Directed stimulus.
  initial begin : estimulo
    int t2_exp[5];
    int t3_exp[5];
    t2_exp = '{0, 255, 64, 192, 128};
    t3_exp = '{32, 48, 80, 112, 128};

    reset = 1'b1; clk_muestra = 1'b0; clr_err = 1'b0;
    bus_if.wr_en = 1'b0; bus_if.dato = 8'h00;
`ifdef AUDIO_VOLUMEN_EN
    vol = 2'd0;
`endif
    repeat (2) step();
    chk(0, 0, "rst_nivel"); chk(1, 0, "rst_lleno"); chk(2, 1, "rst_vacio");
    chk(3, 0, "rst_repro"); chk(6, 0, "rst_pwm");   chk(4, 0, "rst_sub");
    chk(5, 0, "rst_des");
    mon_en = 1'b1;
    duty_q.push_back(128);
    step();
    reset = 1'b0;

    // Below threshold: ticks ignored; reaching PROF/2 starts playback.
    escribir(8'h00); escribir(8'hFF); escribir(8'h40);
    pulso(2, 3);
    chk(0, 3, "nivel_bajo_umbral"); chk(3, 0, "espera_ignora_tick");
    escribir(8'hC0);
    chk(0, 4, "nivel_umbral"); chk(3, 0, "espera_antes_arranque");
    step();
    chk(3, 1, "arranque");

    // Playback at 1602 clk per sample, then underrun to midscale.
    for (int i = 0; i < 5; i++) begin
      duty_q.push_back(t2_exp[i]);
      pulso(801, 801);
    end
    chk(4, 1, "sub_t2"); chk(3, 0, "espera_t2"); chk(2, 1, "vacio_t2");

    // Drain to one sample, last pop, then underrun.
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk(4, 0, "clr_sub");
    escribir(8'h20); escribir(8'h30); escribir(8'h50); escribir(8'h70);
    step();
    chk(3, 1, "arranque_t3");
    for (int i = 0; i < 3; i++) begin
      duty_q.push_back(t3_exp[i]);
      pulso(300, 300);
    end
    chk(0, 1, "nivel_uno"); chk(3, 1, "repro_nivel_uno");
    duty_q.push_back(t3_exp[3]);
    pulso(300, 300);
    chk(0, 0, "ultimo_pop"); chk(4, 0, "sin_sub_ultimo_pop"); chk(3, 1, "sigue_repro");
    duty_q.push_back(t3_exp[4]);
    pulso(300, 300);
    chk(4, 1, "sub_t3"); chk(3, 0, "espera_t3");
    mon_en = 1'b0;

    // Overflow, clearing, and write/pop interactions at full and mid level.
    clr_err = 1'b1; step(); clr_err = 1'b0;
    for (int i = 0; i < 9; i++) escribir(8'hFF);
    chk(0, 8, "nivel_lleno"); chk(1, 1, "lleno"); chk(5, 1, "desborde"); chk(2, 0, "no_vacio");
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk(5, 0, "clr_des"); chk(0, 8, "nivel_tras_clr");
    clr_err = 1'b1; bus_if.wr_en = 1'b1; step(); clr_err = 1'b0; bus_if.wr_en = 1'b0;
    chk(5, 1, "clr_vs_error"); chk(0, 8, "nivel_clr_vs_error");
    clr_err = 1'b1; step(); clr_err = 1'b0;
    clk_muestra = 1'b1; bus_if.wr_en = 1'b1; step(); bus_if.wr_en = 1'b0;
    chk(0, 7, "pop_con_lleno"); chk(5, 1, "des_lleno_pop");
    clk_muestra = 1'b0; step();
    clk_muestra = 1'b1; bus_if.wr_en = 1'b1; step(); bus_if.wr_en = 1'b0;
    chk(0, 7, "wr_pop_simultaneo"); chk(1, 0, "no_lleno");

    // Asynchronous reset mid-period while playing duty 255.
    repeat (300) step();
    for (int k = 0; k < 300 && (cyc % 256) != 100; k++) step();
    chk(6, 1, "pwm_antes_reset"); chk(3, 1, "repro_antes_reset");
    ->chk_ev;
    #2 reset = 1'b1;
    #1;
    chk(6, 0, "reset_pwm"); chk(0, 0, "reset_nivel"); chk(2, 1, "reset_vacio");
    chk(3, 0, "reset_repro"); chk(5, 0, "reset_des");
    ->chk_ev;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) escribir(8'h10);
    repeat (10) step();
    chk(0, 5, "sin_tick_tras_reset"); chk(3, 1, "repro_tras_reset"); chk(4, 0, "sub_tras_reset");
    clk_muestra = 1'b0; step();
    clk_muestra = 1'b1; step();
    chk(0, 4, "tick_tras_bajada");
    clk_muestra = 1'b0;

`ifdef AUDIO_VOLUMEN_EN
    // Volume scaling: vol=2 maps FF to 9F and 00 to 60.
    reset = 1'b1; step();
    vol = 2'd2;
    mon_en = 1'b1;
    duty_q.push_back(128);
    step();
    reset = 1'b0;
    escribir(8'hFF); escribir(8'h00); escribir(8'hFF); escribir(8'h00);
    step();
    duty_q.push_back(159);
    pulso(300, 300);
    duty_q.push_back(96);
    pulso(300, 300);
    mon_en = 1'b0;
`endif

    step(); step();
    n_vec++;
    if (duty_q.size() != 0) begin
      n_err++;
      $display("FAIL duty_pendientes: got %0d unseen duties, expected 0", duty_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
